// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: issues in-order word fetches, queues returned words in a prefetch FIFO
// and presents {PC+4, Instruction} to IF/ID. Define IF_FETCH_BYPASS_EN for the zero-latency empty-FIFO bypass.
module if_fetch_unit #(
   parameter int          FIFO_DEPTH = 4,
   parameter int          MAX_OUTST  = 2,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        freeze,
   input  logic        SRAM_freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC,
   output logic [31:0] Instruction,
   output logic        inst_valid
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int OW = 3;
   localparam int SW = CW + OW + 1;
   localparam logic [OW-1:0] MAX_O   = OW'(MAX_OUTST);
   localparam logic [SW-1:0] DEPTH_S = SW'(FIFO_DEPTH);

   logic [31:0]   fetchPc_q, fetchPc_d;
   logic [31:0]   respPc_q, respPc_d;
   logic [OW-1:0] outst_q, outst_d;
   logic [OW-1:0] discard_q, discard_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] wrPtr_q, wrPtr_d;
   logic [AW-1:0] rdPtr_q, rdPtr_d;
   logic          runEn_q;

   logic [31:0]   pcMem   [FIFO_DEPTH];
   logic [31:0]   instMem [FIFO_DEPTH];

   logic [SW-1:0] credit;
   logic          issue;
   logic          rspAccept;
   logic          fifoEmpty;
   logic          bypass;
   logic          pop;
   logic          fifoPush;
   logic          fifoPop;

   // Credit pre-reserves a FIFO slot for every live in-flight request, so a push can never overflow.
   assign credit    = SW'(count_q) + SW'(outst_q) - SW'(discard_q);
   assign imem_req  = runEn_q && !branch_taken && (outst_q < MAX_O) && (credit < DEPTH_S);
   assign imem_addr = fetchPc_q;
   assign issue     = imem_req && imem_gnt;
   assign rspAccept = imem_rvalid && !branch_taken && (discard_q == '0);
   assign fifoEmpty = (count_q == '0);

`ifdef IF_FETCH_BYPASS_EN
   assign bypass = runEn_q && fifoEmpty && rspAccept;
`else
   assign bypass = 1'b0;
`endif

   always_comb begin
      inst_valid  = 1'b0;
      PC          = 32'h0;
      Instruction = 32'h0;
      if (bypass) begin
         inst_valid  = 1'b1;
         PC          = respPc_q + 32'd4;
         Instruction = imem_rdata;
      end else if (!fifoEmpty) begin
         inst_valid  = 1'b1;
         PC          = pcMem[rdPtr_q];
         Instruction = instMem[rdPtr_q];
      end
   end

   assign pop      = inst_valid && !freeze && !SRAM_freeze && !branch_taken;
   assign fifoPop  = pop && !bypass;
   assign fifoPush = rspAccept && !(bypass && pop);

   // A redirect overrides everything; responses still in flight at that point become discards.
   always_comb begin
      fetchPc_d = fetchPc_q;
      respPc_d  = respPc_q;
      outst_d   = outst_q;
      discard_d = discard_q;
      count_d   = count_q;
      wrPtr_d   = wrPtr_q;
      rdPtr_d   = rdPtr_q;
      if (issue) begin
         fetchPc_d = fetchPc_q + 32'd4;
         outst_d   = outst_q + 3'd1;
      end
      if (imem_rvalid) begin
         outst_d = outst_d - 3'd1;
      end
      if (branch_taken) begin
         fetchPc_d = branch_addr & ~32'd3;
         respPc_d  = branch_addr & ~32'd3;
         discard_d = outst_d;
         count_d   = '0;
         wrPtr_d   = '0;
         rdPtr_d   = '0;
      end else begin
         if (imem_rvalid && (discard_q != '0)) begin
            discard_d = discard_q - 3'd1;
         end
         if (rspAccept) begin
            respPc_d = respPc_q + 32'd4;
         end
         if (fifoPush) begin
            wrPtr_d = wrPtr_q + AW'(1);
         end
         if (fifoPop) begin
            rdPtr_d = rdPtr_q + AW'(1);
         end
         count_d = count_q + CW'(fifoPush) - CW'(fifoPop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetchPc_q <= RESET_PC;
         respPc_q  <= RESET_PC;
         outst_q   <= '0;
         discard_q <= '0;
         count_q   <= '0;
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
         runEn_q   <= 1'b0;
      end else begin
         fetchPc_q <= fetchPc_d;
         respPc_q  <= respPc_d;
         outst_q   <= outst_d;
         discard_q <= discard_d;
         count_q   <= count_d;
         wrPtr_q   <= wrPtr_d;
         rdPtr_q   <= rdPtr_d;
         runEn_q   <= 1'b1;
      end
   end

   // Storage needs no reset: the occupancy count alone decides what is visible.
   always_ff @(posedge clk) begin
      if (fifoPush) begin
         pcMem[wrPtr_q]   <= respPc_q + 32'd4;
         instMem[wrPtr_q] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: in-order memory responder, stream scoreboard, and targeted
// freeze / redirect / grant-stall / reset scenarios. Works with or without IF_FETCH_BYPASS_EN.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        freeze;
   logic        SRAM_freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata  = 32'h0;
   logic [31:0] PC;
   logic [31:0] Instruction;
   logic        inst_valid;

   int          testCount = 0;
   int          failCount = 0;
   logic        rspHold;

   if_fetch_unit #(.FIFO_DEPTH(4), .MAX_OUTST(2), .RESET_PC(32'h0)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .freeze       (freeze),
      .SRAM_freeze  (SRAM_freeze),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_gnt     (imem_gnt),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .PC           (PC),
      .Instruction  (Instruction),
      .inst_valid   (inst_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic gntV, input logic frzV, input logic sfrzV,
                                input logic brV, input logic [31:0] brAddrV, input logic holdV);
      @(posedge clk);
      #1;
      imem_gnt     = gntV;
      freeze       = frzV;
      SRAM_freeze  = sfrzV;
      branch_taken = brV;
      branch_addr  = brAddrV;
      rspHold      = holdV;
   endtask

   task automatic waitCond(input string tag, input int which);
      bit hit = 1'b0;
      for (int n = 0; n < 30 && !hit; n++) begin
         @(negedge clk);
         case (which)
            0:       hit = inst_valid;
            1:       hit = !imem_req && !inst_valid;
            default: hit = imem_rvalid;
         endcase
      end
      if (!hit) checkOutput({tag, "Timeout"}, 32'd0, 32'd1);
   endtask

   // Memory model: responses return in order, one cycle after grant unless held back.
   logic        fireSeen = 1'b0;
   logic [31:0] fireAddr = 32'h0;
   logic [31:0] rspQ[$];

   always @(negedge clk) begin
      fireSeen = rst_n && imem_req && imem_gnt;
      fireAddr = imem_addr;
   end

   always begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
         rspQ.delete();
         imem_rvalid = 1'b0;
         imem_rdata  = 32'h0;
      end else begin
         if (fireSeen) rspQ.push_back(fireAddr);
         if (!rspHold && rspQ.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memWord(rspQ.pop_front());
         end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
         end
      end
   end

   // Scoreboard: sequential request addresses and delivered words, restarted by reset or redirect.
   logic [31:0] expReqAddr = 32'h0;
   logic [31:0] expPc      = 32'h4;

   always @(negedge clk) begin
      if (!rst_n) begin
         expReqAddr = 32'h0;
         expPc      = 32'h4;
      end else if (branch_taken) begin
         checkOutput("reqInBranch", 32'(imem_req), 32'd0);
         expReqAddr = branch_addr & ~32'd3;
         expPc      = expReqAddr + 32'd4;
      end else begin
         if (imem_req && imem_gnt) begin
            checkOutput("reqAddr", imem_addr, expReqAddr);
            expReqAddr = expReqAddr + 32'd4;
         end
         if (inst_valid && !freeze && !SRAM_freeze) begin
            checkOutput("popPc", PC, expPc);
            checkOutput("popInst", Instruction, memWord(expPc - 32'd4));
            expPc = expPc + 32'd4;
         end
      end
   end

   logic [31:0] heldPc;
   logic [31:0] heldInst;
   logic [31:0] heldAddr;

   initial begin
      rst_n        = 1'b0;
      imem_gnt     = 1'b1;
      freeze       = 1'b0;
      SRAM_freeze  = 1'b0;
      branch_taken = 1'b0;
      branch_addr  = 32'h0;
      rspHold      = 1'b0;

      @(negedge clk);
      @(negedge clk);
      checkOutput("rstReq", 32'(imem_req), 32'd0);
      checkOutput("rstAddr", imem_addr, 32'h0);
      checkOutput("rstPc", PC, 32'h0);
      checkOutput("rstInst", Instruction, 32'h0);
      checkOutput("rstValid", 32'(inst_valid), 32'd0);

      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Free-running stream: once filled, one instruction every cycle.
      waitCond("firstValid", 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checkOutput("streamValid", 32'(inst_valid), 32'd1);
      end

      // Hazard freeze: head held, fetch stops once credit is used up.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      heldPc   = PC;
      heldInst = Instruction;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("freezePc", PC, heldPc);
         checkOutput("freezeInst", Instruction, heldInst);
      end
      checkOutput("fullReqLow", 32'(imem_req), 32'd0);
      checkOutput("fullValid", 32'(inst_valid), 32'd1);

      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("sramFreezePc", PC, heldPc);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      repeat (6) @(negedge clk);

      // Redirect with two requests in flight: both stale words must vanish.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      waitCond("twoOutstanding", 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      waitCond("branchValid", 0);
      checkOutput("branchPc", PC, 32'h0000_0104);
      checkOutput("branchInst", Instruction, memWord(32'h0000_0100));
      repeat (4) @(negedge clk);

      // Grant withheld: address frozen, pipeline drains to bubbles.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      heldAddr = imem_addr;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("gntHoldAddr", imem_addr, heldAddr);
      end
      checkOutput("drainValid", 32'(inst_valid), 32'd0);
      checkOutput("drainInst", Instruction, 32'h0);
      checkOutput("drainPc", PC, 32'h0);
      checkOutput("drainReq", 32'(imem_req), 32'd1);

      // Redirect in the same cycle as the only response: word dropped, nothing left to discard.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
      @(negedge clk);
      checkOutput("rvalidInBranch", 32'(imem_rvalid), 32'd1);
      checkOutput("branchCycleValid", 32'(inst_valid), 32'd0);
      checkOutput("branchCycleInst", Instruction, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      waitCond("branch2Valid", 0);
      checkOutput("branch2Pc", PC, 32'h0000_0204);
      checkOutput("branch2Inst", Instruction, memWord(32'h0000_0200));
      repeat (4) @(negedge clk);

      // Asynchronous reset with a partly filled FIFO.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      repeat (3) @(negedge clk);
      checkOutput("preResetValid", 32'(inst_valid), 32'd1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("asyncRstValid", 32'(inst_valid), 32'd0);
      checkOutput("asyncRstPc", PC, 32'h0);
      checkOutput("asyncRstInst", Instruction, 32'h0);
      checkOutput("asyncRstReq", 32'(imem_req), 32'd0);
      checkOutput("asyncRstAddr", imem_addr, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      waitCond("restartRvalid", 2);
`ifdef IF_FETCH_BYPASS_EN
      checkOutput("restartValid", 32'(inst_valid), 32'd1);
      checkOutput("restartPc", PC, 32'h4);
      checkOutput("restartInst", Instruction, memWord(32'h0));
`else
      checkOutput("restartValid", 32'(inst_valid), 32'd0);
      checkOutput("restartInst", Instruction, 32'h0);
`endif
      @(negedge clk);
      checkOutput("restartNextValid", 32'(inst_valid), 32'd1);
      repeat (6) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
